alu_muldiv: RTL
===============

# alu_muldiv

Parametrised successor to the datapath ALU: single-cycle combinational logic/shift/compare ops plus a multi-cycle iterative multiply/divide unit that writes architectural HI/LO registers. It adds unsigned multiply, signed and unsigned divide, and a start/busy/done handshake so the pipeline can stall on long operations. It sits in the execute stage; the control unit drives `ALUop` and `start`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; even, ≥ 8. The shift amount is `SHW = $clog2(WIDTH)` low bits of `a`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ALUop`  in  5  operation select; encodings below.
- `a`, `b`  in  WIDTH  operands.
- `start`  in  1  launches a sequential op (mult/multu/div/divu/mthi/mtlo).
- `result`  out  WIDTH  combinational result.
- `busy`  out  1  iterative op in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- `hi`, `lo`  out  WIDTH  current HI/LO register contents.

## Operation
- Combinational ops, `result` valid in the same cycle, no `start` needed:
  - 00000 add, 00001 sub, 00010 and, 00011 or, 00100 nor, 00101 xor.
  - 00110 sll (`b << a[SHW-1:0]`), 00111 srl, 01000 sra (arithmetic on `b`).
  - 01010 sltu and 01011 slt produce 1 or 0, zero-extended.
  - 01100 mflo and 01101 mfhi output `lo`/`hi` combinationally.
  - All other codes, including 01001, output 0.
- Sequential ops, accepted only on an edge with `start`=1 and `busy`=0:
  - 01110 mthi: `hi`←`a` at that edge. 01111 mtlo: `lo`←`a`. No busy, no done.
  - 10000 mult (signed), 10001 multu, 10010 div (signed), 10011 divu. The operands are latched and the FSM enters RUN.
  - Other codes with `start` are ignored.
- FSM states IDLE → RUN → FIX → IDLE.
  - RUN performs WIDTH radix-2 iterations on operand magnitudes: shift-add for multiply, restoring subtract for divide.
  - FIX applies sign correction, writes `hi`/`lo`, and pulses `done`.
- Multiply: {hi,lo} = full 2·WIDTH-bit product.
- Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- Divide by zero: lo = all ones, hi = dividend (`a`). Same latency, no exception.
- Signed overflow (−2^(WIDTH−1) / −1): lo = −2^(WIDTH−1), hi = 0.
- `start` while `busy`=1 is ignored, including mthi/mtlo. HI/LO are not modified.
- mfhi/mflo while busy return the old HI/LO values. Stalling is the controller's responsibility.
- Operand changes on `a`/`b` after the accepting edge have no effect on the running op.

## Timing
- Reset (synchronous, `rst`=1 at an edge): `hi`=`lo`=0, `busy`=0, `done`=0, FSM=IDLE.
- `result` is combinational and has no reset value; with `hi`/`lo`=0 after reset, mfhi/mflo read 0.
- Reset during RUN/FIX aborts the op; HI/LO are cleared and `done` does not pulse. `rst` has priority over `start` on the same edge.
- Accepting edge E0: `busy`=1 from after E0.
- RUN iterations occur at edges E1..E_WIDTH; FIX occurs at E_{WIDTH+1}.
- After E_{WIDTH+1}: `hi`/`lo` are new, `done`=1, and `busy`=0 in the same cycle.
- Latency: WIDTH+1 cycles from accepting edge to `done` (33 at WIDTH=32).
- `done` stays high exactly one cycle.
- A new `start` may be accepted on the edge that ends the `done` cycle, giving back-to-back ops with no idle gap.
- mthi/mtlo: the new value is visible on `hi`/`lo` and on mfhi/mflo the cycle after the accepting edge.

## Test plan
- Combinational sweep, WIDTH=32:
  - sra `b`=0x80000000, `a`=4 → 0xF8000000.
  - sltu 0xFFFFFFFF vs 1 → 0; slt 0xFFFFFFFF vs 1 → 1.
  - add 0xFFFFFFFF+1 → 0.
- Multiply:
  - multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, `done` exactly 33 cycles after start, `busy` high 33 cycles.
  - mult −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Divide:
  - div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 → lo=0xFFFFFFFF, hi=7.
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake:
  - During busy, pulse start with mtlo `a`=0x1234 → lo unchanged, final result correct.
  - Second mult issued on the done-cycle edge is accepted, and its `done` arrives 33 cycles later.
  - mfhi during busy returns the old HI.
- Reset:
  - Assert `rst` at cycle 10 of a divu → `busy`=0, `done` never pulses, hi=lo=0.
  - mthi 0xA5A5A5A5 afterwards → mfhi returns 0xA5A5A5A5 next cycle.
- Parameter: WIDTH=16, mult 0x8000×0x8000 → hi=0x4000, lo=0x0000, latency 17.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU ops plus an iterative multiply/divide unit that
// owns the architectural HI/LO registers.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting; accepts mthi/mtlo directly or launches mult/div
//   S_RUN  | WIDTH radix-2 iterations on operand magnitudes
//   S_FIX  | sign correction, HI/LO write-back, done pulse
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_NOR  = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_MFLO = 5'b01100;
  localparam logic [4:0] OP_MFHI = 5'b01101;
  localparam logic [4:0] OP_MTHI = 5'b01110;
  localparam logic [4:0] OP_MTLO = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] p_hi;     // product high / partial remainder
  logic [WIDTH-1:0] p_lo;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw;    // original dividend, returned as HI on divide by zero
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_p;    // negate product or quotient at FIX
  logic             neg_r;    // negate remainder at FIX
  logic             div_zero;

  logic             launch;
  logic             op_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // mult/multu/div/divu are 100xx; bit 0 clear selects the signed variant
  assign launch    = start && (state == S_IDLE) && (ALUop[4:2] == 3'b100);
  assign op_signed = ~ALUop[0];
  assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign shamt     = a[SHW-1:0];
  assign busy      = (state != S_IDLE);

  // Single-cycle ALU result, including combinational HI/LO reads
  always_comb begin
    result = '0;
    case (ALUop)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = $signed(b) >>> shamt;
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFLO: result = lo;
      OP_MFHI: result = hi;
      default: result = '0;
    endcase
  end

  // One iteration step for each algorithm plus the sign-corrected final values
  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    // when div_ge holds the true difference is below the divisor, so W bits suffice
    div_rem   = div_shift[WIDTH-1:0] - mcand;
    prod_fix  = neg_p ? -{p_hi, p_lo} : {p_hi, p_lo};
    quo_fix   = neg_p ? -p_lo : p_lo;
    rem_fix   = neg_r ? -p_hi : p_hi;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; the iteration counter's terminal count ends RUN
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (launch) state_n = S_RUN;
      S_RUN:   if (cnt == '0) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      p_hi     <= '0;
      p_lo     <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ALUop == OP_MTHI) begin
              hi <= a;
            end else if (ALUop == OP_MTLO) begin
              lo <= a;
            end else if (launch) begin
              op_div   <= ALUop[1];
              neg_p    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= op_signed && a[WIDTH-1];
              div_zero <= (b == '0);
              a_raw    <= a;
              mcand    <= abs_b;
              p_lo     <= abs_a;
              p_hi     <= '0;
              cnt      <= ITER_LAST;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (op_div) begin
            p_hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
          end else begin
            p_hi <= mul_sum[WIDTH:1];
            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            lo <= '1;
            hi <= a_raw;
          end else begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
